// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch stage:
//   fetch_state_e     - fetch sequencer state (2-bit encoding)
//   NOP_INSTR         - instruction word held while nothing has been fetched
//   DEFAULT_RESET_PC  - default PC value loaded on reset
// -----------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH_REQ  = 2'd0,  // presenting a request on the imem request channel
        FETCH_WAIT = 2'd1,  // request accepted, waiting for the response beat
        FETCH_EXEC = 2'd2,  // instruction held for decode/execute until retire
        FETCH_HALT = 2'd3   // misaligned target seen; only reset leaves here
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0, x0, 0
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage : fetch_pkg

// File: rtl/fetch_next_pc.sv
// -----------------------------------------------------------------------------
// fetch_next_pc
// Purely combinational next-PC selection, shared with the pipelined fetch.
// Ports:
//   pc         in  XLEN  current PC
//   imm_ext    in  XLEN  sign-extended immediate from decode
//   cs_branch  in  1     branch instruction
//   cs_jump    in  1     jal instruction
//   zero       in  1     ALU zero flag (branch condition)
//   next_pc    out XLEN  selected successor PC
//   pc_plus4   out XLEN  sequential successor PC
//   misaligned out 1     selected successor is not 4-byte aligned
// All arithmetic is modulo 2^XLEN; wrap-around is intentional and silent.
// -----------------------------------------------------------------------------
module fetch_next_pc #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm_ext,
    input  logic            cs_branch,
    input  logic            cs_jump,
    input  logic            zero,
    output logic [XLEN-1:0] next_pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            misaligned
);

    logic            take_target;
    logic [XLEN-1:0] target_pc;

    always_comb begin
        pc_plus4    = pc + XLEN'(4);
        target_pc   = pc + imm_ext;
        // A taken branch and jal share the same pc-relative adder.
        take_target = cs_jump | (cs_branch & zero);
        next_pc     = take_target ? target_pc : pc_plus4;
        // Only the selected successor matters: a misaligned target on a
        // not-taken branch is harmless.
        misaligned  = (next_pc[1:0] != 2'b00);
    end

endmodule : fetch_next_pc

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage in front of the single-cycle control unit. Owns the
// PC, requests one instruction at a time from instruction memory, holds it for
// the datapath until it retires, then advances the PC using the control unit's
// branch/jump outcome.
// Ports:
//   clk, rst        clock (rising edge) and asynchronous active-high reset
//   imem_req_valid  out  request valid (registered)
//   imem_req_ready  in   memory accepts the request
//   imem_req_addr   out  request address, always equal to pc
//   imem_rsp_valid  in   response beat valid
//   imem_rsp_data   in   returned instruction word
//   retire          in   datapath finished the held instruction this cycle
//   cs_branch       in   branch instruction
//   cs_jump         in   jal instruction
//   zero            in   ALU zero flag
//   imm_ext         in   sign-extended immediate
//   instr           out  held instruction word (registered)
//   instr_valid     out  instr/pc valid for execution (registered)
//   pc, pc_plus4    out  current PC and PC+4 (combinational from pc register)
//   fetch_fault     out  sticky: retire selected a misaligned target
//   proto_err       out  sticky: response beat arrived outside WAIT
// Sequence per instruction: REQ (accepted) -> WAIT (response) -> EXEC (retire),
// so an instruction costs at least three cycles.
// -----------------------------------------------------------------------------
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            retire,
    input  logic            cs_branch,
    input  logic            cs_jump,
    input  logic            zero,
    input  logic [XLEN-1:0] imm_ext,
    output logic [31:0]     instr,
    output logic            instr_valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            fetch_fault,
    output logic            proto_err
);

    // The reset PC is meant to be word aligned; the low bits are forced to
    // zero so a bad override can never produce a misaligned first fetch.
    localparam logic [XLEN-1:0] RESET_PC_ALIGNED = {RESET_PC[XLEN-1:2], 2'b00};

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic            req_valid_q, req_valid_d;
    logic            instr_valid_q, instr_valid_d;
    logic            fetch_fault_q, fetch_fault_d;
    logic            proto_err_q, proto_err_d;

    logic [XLEN-1:0] next_pc;
    logic            next_misaligned;

    fetch_next_pc #(
        .XLEN (XLEN)
    ) u_next_pc (
        .pc         (pc_q),
        .imm_ext    (imm_ext),
        .cs_branch  (cs_branch),
        .cs_jump    (cs_jump),
        .zero       (zero),
        .next_pc    (next_pc),
        .pc_plus4   (pc_plus4),
        .misaligned (next_misaligned)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        fetch_fault_d = fetch_fault_q;
        proto_err_d   = proto_err_q;

        // A response beat is only legal while a request is outstanding.
        // Anywhere else the data is dropped and the error latched; this also
        // covers a response in the same cycle the request is accepted.
        if (imem_rsp_valid && (state_q != FETCH_WAIT)) begin
            proto_err_d = 1'b1;
        end

        unique case (state_q)
            FETCH_REQ: begin
                // req_valid_q is low for the first cycle out of reset, and a
                // ready seen then must not count as an accepted request.
                if (req_valid_q && imem_req_ready) begin
                    state_d = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (imem_rsp_valid) begin
                    instr_d = imem_rsp_data;
                    state_d = FETCH_EXEC;
                end
            end
            FETCH_EXEC: begin
                if (retire) begin
                    if (next_misaligned) begin
                        // PC stays on the faulting instruction for debug.
                        fetch_fault_d = 1'b1;
                        state_d       = FETCH_HALT;
                    end else begin
                        pc_d    = next_pc;
                        state_d = FETCH_REQ;
                    end
                end
            end
            FETCH_HALT: begin
                state_d = FETCH_HALT;
            end
            default: begin
                state_d = FETCH_HALT;
            end
        endcase

        // Handshake outputs are registered copies of the next-state decode so
        // they line up with state_q without any combinational path.
        req_valid_d   = (state_d == FETCH_REQ);
        instr_valid_d = (state_d == FETCH_EXEC);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= FETCH_REQ;
            pc_q          <= RESET_PC_ALIGNED;
            instr_q       <= NOP_INSTR;
            req_valid_q   <= 1'b0;
            instr_valid_q <= 1'b0;
            fetch_fault_q <= 1'b0;
            proto_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            req_valid_q   <= req_valid_d;
            instr_valid_q <= instr_valid_d;
            fetch_fault_q <= fetch_fault_d;
            proto_err_q   <= proto_err_d;
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = pc_q;
    assign instr          = instr_q;
    assign instr_valid    = instr_valid_q;
    assign pc             = pc_q;
    assign fetch_fault    = fetch_fault_q;
    assign proto_err      = proto_err_q;

endmodule : fetch_unit
